// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - shared state encoding and timer sizing for traffic_intersection_ctrl
package tl_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        RED_TO_EW = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        RED_TO_NS = 3'd5,
        NIGHT_ON  = 3'd6,
        NIGHT_OFF = 3'd7
    } tl_state_e;

    function automatic int max_duration(input int a, input int b, input int c,
                                        input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

endpackage

// File: rtl/traffic_intersection_ctrl_phase_timer.sv
// rtl/traffic_intersection_ctrl_phase_timer.sv - loadable down-counter that times each phase
module phase_timer #(
    parameter int               CNT_W       = 5,
    parameter logic [CNT_W-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RESET_VALUE;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// rtl/traffic_intersection_ctrl.sv - two-road lamp sequencer with pedestrian walk and night flash
module traffic_intersection_ctrl
    import tl_pkg::*;
#(
    parameter int T_GREEN     = 20,
    parameter int T_YELLOW    = 10,
    parameter int T_ALLRED    = 4,
    parameter int T_MIN_GREEN = 8,
    parameter int T_WALK      = 12,
    parameter int T_FLASH     = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ped_req,
    input  logic       night_mode,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       ped_walk,
    output logic [2:0] phase
);

    localparam int CNT_W = $clog2(max_duration(T_GREEN, T_YELLOW, T_ALLRED, T_WALK, T_FLASH) + 1);

    localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] LD_WALK   = CNT_W'(T_WALK - 1);
    localparam logic [CNT_W-1:0] LD_FLASH  = CNT_W'(T_FLASH - 1);
    // Timer value at which T_MIN_GREEN green cycles have elapsed, counting the current one.
    localparam logic [CNT_W-1:0] GREEN_CUT = CNT_W'(T_GREEN - T_MIN_GREEN);

    tl_state_e        state_q, state_d;
    logic             ped_pending_q, ped_pending_d;
    logic             walk_flag_q, walk_flag_d;
    logic             advance;
    logic             green_cut;
    logic [CNT_W-1:0] load_value;
    logic [CNT_W-1:0] timer_count;
    logic             timer_zero;

    phase_timer #(
        .CNT_W       (CNT_W),
        .RESET_VALUE (LD_ALLRED)
    ) u_phase_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (advance),
        .load_value (load_value),
        .count      (timer_count),
        .zero       (timer_zero)
    );

    assign green_cut = (state_q == NS_GREEN || state_q == EW_GREEN) && ped_pending_q
                       && (timer_count <= GREEN_CUT);
    assign advance   = timer_zero || green_cut;

    always_comb begin
        state_d       = state_q;
        load_value    = '0;
        walk_flag_d   = walk_flag_q;
        ped_pending_d = ped_pending_q | ped_req;

        if (advance) begin
            case (state_q)
                NS_GREEN:  state_d = NS_YELLOW;
                NS_YELLOW: state_d = RED_TO_EW;
                RED_TO_EW: state_d = night_mode ? NIGHT_ON : EW_GREEN;
                EW_GREEN:  state_d = EW_YELLOW;
                EW_YELLOW: state_d = RED_TO_NS;
                RED_TO_NS: state_d = night_mode ? NIGHT_ON : NS_GREEN;
                NIGHT_ON:  state_d = NIGHT_OFF;
                NIGHT_OFF: state_d = night_mode ? NIGHT_ON : RED_TO_NS;
                default:   state_d = RED_TO_NS;
            endcase

            walk_flag_d = 1'b0;
            case (state_d)
                NS_GREEN, EW_GREEN:   load_value = LD_GREEN;
                NS_YELLOW, EW_YELLOW: load_value = LD_YELLOW;
                RED_TO_EW, RED_TO_NS: begin
                    // A pending request stretches the clearance into a walk; a press on this same edge stays latched.
                    if (ped_pending_q) begin
                        load_value    = LD_WALK;
                        walk_flag_d   = 1'b1;
                        ped_pending_d = ped_req;
                    end else begin
                        load_value    = LD_ALLRED;
                    end
                end
                default:              load_value = LD_FLASH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RED_TO_NS;
            ped_pending_q <= 1'b0;
            walk_flag_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ped_pending_q <= ped_pending_d;
            walk_flag_q   <= walk_flag_d;
        end
    end

    always_comb begin
        ns_red    = 1'b0;
        ns_yellow = 1'b0;
        ns_green  = 1'b0;
        ew_red    = 1'b0;
        ew_yellow = 1'b0;
        ew_green  = 1'b0;
        ped_walk  = 1'b0;
        case (state_q)
            NS_GREEN:  begin ns_green  = 1'b1; ew_red    = 1'b1; end
            NS_YELLOW: begin ns_yellow = 1'b1; ew_red    = 1'b1; end
            EW_GREEN:  begin ew_green  = 1'b1; ns_red    = 1'b1; end
            EW_YELLOW: begin ew_yellow = 1'b1; ns_red    = 1'b1; end
            RED_TO_EW, RED_TO_NS: begin
                ns_red   = 1'b1;
                ew_red   = 1'b1;
                ped_walk = walk_flag_q;
            end
            NIGHT_ON:  begin ns_yellow = 1'b1; ew_yellow = 1'b1; end
            default:   ;
        endcase
    end

    assign phase = state_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// tb/tb_traffic_intersection_ctrl.sv - self-checking bench with a phase-duration model and directed scenarios
module tb_traffic_intersection_ctrl;

    localparam int TG  = 8;
    localparam int TY  = 3;
    localparam int TA  = 2;
    localparam int TMG = 4;
    localparam int TW  = 5;
    localparam int TF  = 2;

    logic       clk;
    logic       rst_n;
    logic       ped_req;
    logic       night_mode;
    logic       ns_red, ns_yellow, ns_green;
    logic       ew_red, ew_yellow, ew_green;
    logic       ped_walk;
    logic [2:0] phase;
    logic [6:0] dut_v;

    int n_checks = 0;
    int n_errors = 0;
    int smp      = 0;
    bit chk_en   = 0;

    // Model: current phase number, cycles spent in it (1-based), latched request, walk flag.
    int m_ph   = 5;
    int m_el   = 1;
    bit m_pend = 0;
    bit m_walk = 0;

    traffic_intersection_ctrl #(
        .T_GREEN     (TG),
        .T_YELLOW    (TY),
        .T_ALLRED    (TA),
        .T_MIN_GREEN (TMG),
        .T_WALK      (TW),
        .T_FLASH     (TF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ped_req    (ped_req),
        .night_mode (night_mode),
        .ns_red     (ns_red),
        .ns_yellow  (ns_yellow),
        .ns_green   (ns_green),
        .ew_red     (ew_red),
        .ew_yellow  (ew_yellow),
        .ew_green   (ew_green),
        .ped_walk   (ped_walk),
        .phase      (phase)
    );

    assign dut_v = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ped_walk};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dur(input int ph, input bit walk);
        case (ph)
            0, 3:    return TG;
            1, 4:    return TY;
            2, 5:    return walk ? TW : TA;
            default: return TF;
        endcase
    endfunction

    // {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk}
    function automatic logic [6:0] exp_lamps(input int ph, input bit walk);
        case (ph)
            0:       return 7'b0011000;
            1:       return 7'b0101000;
            3:       return 7'b1000010;
            4:       return 7'b1000100;
            2, 5:    return {6'b100100, walk};
            6:       return 7'b0100100;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic model_step();
        int nx;
        bit done;
        nx   = m_ph;
        done = (m_el >= dur(m_ph, m_walk));
        if ((m_ph == 0 || m_ph == 3) && m_pend && m_el >= TMG) done = 1'b1;
        if (done) begin
            case (m_ph)
                0:       nx = 1;
                1:       nx = 2;
                2:       nx = night_mode ? 6 : 3;
                3:       nx = 4;
                4:       nx = 5;
                5:       nx = night_mode ? 6 : 0;
                6:       nx = 7;
                default: nx = night_mode ? 6 : 5;
            endcase
            m_walk = 1'b0;
            if ((nx == 2 || nx == 5) && m_pend) begin
                m_walk = 1'b1;
                m_pend = 1'b0;
            end
            m_ph = nx;
            m_el = 1;
        end else begin
            m_el = m_el + 1;
        end
        if (ped_req) m_pend = 1'b1;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_ph   = 5;
            m_el   = 1;
            m_pend = 1'b0;
            m_walk = 1'b0;
        end else begin
            model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            n_checks++;
            if (phase !== 3'(m_ph) || dut_v !== exp_lamps(m_ph, m_walk)) begin
                n_errors++;
                $display("FAIL model t=%0t phase=%0d lamps=%b expected phase=%0d lamps=%b",
                         $time, phase, dut_v, m_ph, exp_lamps(m_ph, m_walk));
            end
        end
    end

    task automatic goto(input int k);
        while (smp < k) begin
            @(negedge clk);
            smp++;
        end
    endtask

    task automatic pin(input string name, input int ph, input bit walk);
        n_checks++;
        if (phase !== 3'(ph) || ped_walk !== walk) begin
            n_errors++;
            $display("FAIL %s smp=%0d phase=%0d walk=%b expected phase=%0d walk=%b",
                     name, smp, phase, ped_walk, ph, walk);
        end
    endtask

    task automatic pin_lamps(input string name, input logic [6:0] exp);
        n_checks++;
        if (dut_v !== exp) begin
            n_errors++;
            $display("FAIL %s smp=%0d lamps=%b expected lamps=%b", name, smp, dut_v, exp);
        end
    endtask

    // Release happens at sample 0; idle cycle has period 26.
    task automatic pin_restart(input string tag);
        pin({tag, "_red0"}, 5, 1'b0);
        goto(1);  pin({tag, "_red1"}, 5, 1'b0);
        goto(2);  pin({tag, "_nsg_first"}, 0, 1'b0);
        goto(9);  pin({tag, "_nsg_last"}, 0, 1'b0);
        goto(10); pin({tag, "_nsy"}, 1, 1'b0);
        goto(13); pin({tag, "_red_ew"}, 2, 1'b0);
        goto(15); pin({tag, "_ewg"}, 3, 1'b0);
        goto(23); pin({tag, "_ewy"}, 4, 1'b0);
        goto(26); pin({tag, "_red_ns"}, 5, 1'b0);
        goto(28); pin({tag, "_period"}, 0, 1'b0);
    endtask

    initial begin
        rst_n      = 1'b1;
        ped_req    = 1'b0;
        night_mode = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        pin_lamps("reset_lamps", 7'b1001000);
        pin("reset_phase", 5, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        smp   = 0;
        pin_restart("boot");

        ped_req = 1'b1;
        goto(29); ped_req = 1'b0;
        goto(31); pin("ped_green_4th", 0, 1'b0);
        goto(32); pin("ped_yellow", 1, 1'b0);
        goto(35); pin("walk_first", 2, 1'b1);
        goto(39); pin("walk_last", 2, 1'b1);
        goto(40); pin("ewg_after_walk", 3, 1'b0);
        goto(47); pin("ewg_full", 3, 1'b0);
        goto(48); pin("ewy_after_walk", 4, 1'b0);

        ped_req = 1'b1;
        goto(51); pin("held_walk1", 5, 1'b1);
        goto(55); ped_req = 1'b0;
        goto(56); pin("held_nsg", 0, 1'b0);
        goto(59); pin("held_nsg_cut", 0, 1'b0);
        goto(60); pin("held_nsy", 1, 1'b0);
        goto(63); pin("held_walk2", 2, 1'b1);
        goto(68); pin("held_ewg", 3, 1'b0);

        goto(70); night_mode = 1'b1;
        goto(75); pin("night_ewg_full", 3, 1'b0);
        goto(76); pin("night_ewy", 4, 1'b0);
        goto(79); pin("night_red_ns", 5, 1'b0);
        goto(81); pin("night_on", 6, 1'b0);
        pin_lamps("night_on_lamps", 7'b0100100);
        goto(83); pin("night_off", 7, 1'b0);
        pin_lamps("night_off_lamps", 7'b0000000);
        goto(85); pin("night_on2", 6, 1'b0);
        night_mode = 1'b0;
        goto(87); pin("day_off", 7, 1'b0);
        goto(89); pin("day_red", 5, 1'b0);
        goto(91); pin("day_nsg", 0, 1'b0);

        goto(112); pin("pre_reset_ewy", 4, 1'b0);
        goto(113);
        #2 rst_n = 1'b0;
        #1 pin_lamps("midreset_lamps", 7'b1001000);
        pin("midreset_phase", 5, 1'b0);
        goto(115);
        rst_n = 1'b1;
        smp   = 0;
        pin_restart("restart");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
